// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - UART word transmitter: word FIFO feeding a byte-framed serial TX line
// Each word leaves as BYTES back-to-back 8N1/8N2 frames; one idle cycle separates words.
module uart_word_tx #(
    parameter int WORD_W       = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WORD_W-1:0]             word_data,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   words_sent
);

    localparam int BYTES = WORD_W / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [IW-1:0] BYTE_LAST  = IW'(BYTES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [IW-1:0]     byte_q, byte_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [31:0]       sent_q, sent_d;

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              push, pop;
    logic [2:0]        bit_nxt;
    logic [7:0]        cur_byte;

    assign word_ready = (count_q != FULL_COUNT);
    assign busy       = (state_q != S_IDLE) | (count_q != '0);
    assign fifo_count = count_q;
    assign words_sent = sent_q;
    assign uart_tx    = tx_q;

    // READY is taken from the pre-pop count, so a push into a full FIFO is dropped even when popping
    always_comb begin
        push     = word_valid & word_ready;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = word_data;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // The byte on the wire is always at one end of the shift word; advancing shifts the next one in
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        sent_d   = sent_q;
        pop      = 1'b0;
        bit_nxt  = bit_q + 3'd1;
        cur_byte = (MSB_FIRST != 0) ? shift_q[WORD_W-1 -: 8] : shift_q[7:0];
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    byte_d  = '0;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (byte_q == BYTE_LAST) begin
                            sent_d  = sent_q + 32'd1;
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            byte_d  = byte_q + 1'b1;
                            shift_d = (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);
                            tx_d    = 1'b0;
                            state_d = S_START;
                        end
                    end else begin
                        bit_d = bit_nxt;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            sent_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            sent_q   <= sent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - self-checking bench for uart_word_tx
// Expected line waveforms come from a frame-level model of bytes, start/stop bits and idle gaps.
module tb_uart_word_tx;

    localparam int CPB = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready, a_tx, a_busy;
    logic [2:0]  a_count;
    logic [31:0] a_ws;
    logic        b_ready, b_tx, b_busy;
    logic [2:0]  b_count;
    logic [31:0] b_ws;
    logic [7:0]  c_data;
    logic        c_valid;
    logic        c_ready, c_tx, c_busy;
    logic [2:0]  c_count;
    logic [31:0] c_ws;

    int checks;
    int failures;
    int exp_ws_a;
    logic exp_q[$];

    uart_word_tx #(.WORD_W(32), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .MSB_FIRST(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .word_data(a_data), .word_valid(a_valid), .word_ready(a_ready),
        .uart_tx(a_tx), .busy(a_busy), .fifo_count(a_count), .words_sent(a_ws));

    uart_word_tx #(.WORD_W(32), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .MSB_FIRST(0), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .word_data(a_data), .word_valid(a_valid), .word_ready(b_ready),
        .uart_tx(b_tx), .busy(b_busy), .fifo_count(b_count), .words_sent(b_ws));

    uart_word_tx #(.WORD_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .MSB_FIRST(1), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .word_data(c_data), .word_valid(c_valid), .word_ready(c_ready),
        .uart_tx(c_tx), .busy(c_busy), .fifo_count(c_count), .words_sent(c_ws));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Appends the line levels (one per clock) for one word's frames to exp_q
    task automatic model_word(input int nbytes, input int sb, input bit msb, input logic [63:0] w);
        logic [7:0] by;
        for (int b = 0; b < nbytes; b++) begin
            by = msb ? 8'(w >> (8 * (nbytes - 1 - b))) : 8'(w >> (8 * b));
            repeat (CPB) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(by[i]);
            repeat (sb * CPB) exp_q.push_back(1'b1);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; a_valid = 1'b0; c_valid = 1'b0; a_data = '0; c_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_tx, a_ready, a_busy, a_count} !== 6'b110_000) begin
            failures++; $display("FAIL reset_a tx/ready/busy/count got=%b required=110000", {a_tx, a_ready, a_busy, a_count});
        end
        checks++;
        if ({b_tx, b_ready, b_busy, b_count} !== 6'b110_000) begin
            failures++; $display("FAIL reset_b tx/ready/busy/count got=%b required=110000", {b_tx, b_ready, b_busy, b_count});
        end
        checks++;
        if ({c_tx, c_ready, c_busy, c_count} !== 6'b110_000) begin
            failures++; $display("FAIL reset_c tx/ready/busy/count got=%b required=110000", {c_tx, c_ready, c_busy, c_count});
        end
        checks++;
        if ((a_ws !== 32'd0) || (b_ws !== 32'd0) || (c_ws !== 32'd0)) begin
            failures++; $display("FAIL reset_words_sent got a=%0d b=%0d c=%0d required 0", a_ws, b_ws, c_ws);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_ws_a = 0;
    endtask

    task automatic test_float_word;
        logic act_a[$];
        logic act_b[$];
        int mism, first;
        logic [7:0] ga, gb, ea, eb;
        @(posedge clk); #1;
        a_data = 32'h3F80_0000; a_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin failures++; $display("FAIL float_ready_before_push got=%b required=1", a_ready); end
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_count, a_tx, a_busy} !== 5'b001_1_1) begin
            failures++; $display("FAIL float_after_push count/tx/busy got=%b required=00111", {a_count, a_tx, a_busy});
        end
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            act_a.push_back(a_tx);
            act_b.push_back(b_tx);
            if (i == 0) begin
                checks++;
                if ({a_count, a_tx} !== 4'b000_0) begin
                    failures++; $display("FAIL float_pop count/tx got=%b required=0000", {a_count, a_tx});
                end
            end
        end
        @(negedge clk);
        exp_ws_a++;
        checks++;
        if ({a_tx, a_busy, b_tx, b_busy} !== 4'b1010 || a_ws !== 32'(exp_ws_a) || b_ws !== 32'(exp_ws_a)) begin
            failures++; $display("FAIL float_end tx/busy a,b got=%b ws a=%0d b=%0d required=1010 ws=%0d",
                                 {a_tx, a_busy, b_tx, b_busy}, a_ws, b_ws, exp_ws_a);
        end
        exp_q.delete();
        model_word(4, 1, 1'b1, 64'h3F80_0000);
        mism = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) if (act_a[i] !== exp_q[i]) begin mism++; if (first < 0) first = i; end
        checks++;
        if (mism != 0) begin failures++; $display("FAIL float_msb_wave mismatches=%0d first_cycle=%0d required 0", mism, first); end
        exp_q.delete();
        model_word(4, 1, 1'b0, 64'h3F80_0000);
        mism = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) if (act_b[i] !== exp_q[i]) begin mism++; if (first < 0) first = i; end
        checks++;
        if (mism != 0) begin failures++; $display("FAIL float_lsb_wave mismatches=%0d first_cycle=%0d required 0", mism, first); end
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 8; i++) begin
                ga[i] = act_a[j * 40 + 4 + 4 * i + 2];
                gb[i] = act_b[j * 40 + 4 + 4 * i + 2];
            end
            ea = 8'(32'h3F80_0000 >> (8 * (3 - j)));
            eb = 8'(32'h3F80_0000 >> (8 * j));
            checks++;
            if (ga !== ea || gb !== eb) begin
                failures++; $display("FAIL float_byte%0d got msb=%h lsb=%h required msb=%h lsb=%h", j, ga, gb, ea, eb);
            end
        end
    endtask

    task automatic test_stop_bits;
        logic [7:0] wq[$];
        logic act[$];
        logic [10:0] pat, got;
        int idx, mism, first;
        logic acc;
        wq.push_back(8'hA5);
        for (int i = 0; i < 3; i++) wq.push_back(8'($urandom));
        idx = 0;
        @(posedge clk); #1;
        c_data = wq[0]; c_valid = 1'b1;
        for (int cyc = 0; cyc < 2 + 4 * 45; cyc++) begin
            @(negedge clk);
            act.push_back(c_tx);
            acc = c_valid && c_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < wq.size()) c_data = wq[idx]; else c_valid = 1'b0;
            end
        end
        pat = 11'b111_0100_1010;
        for (int i = 0; i < 11; i++) got[i] = act[2 + 4 * i + 2];
        checks++;
        if (got !== pat) begin failures++; $display("FAIL stop2_a5_frame got=%b required=%b", got, pat); end
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        foreach (wq[k]) begin model_word(1, 2, 1'b1, 64'(wq[k])); exp_q.push_back(1'b1); end
        mism = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) if (act[i] !== exp_q[i]) begin mism++; if (first < 0) first = i; end
        checks++;
        if (mism != 0) begin failures++; $display("FAIL stop2_wave mismatches=%0d first_cycle=%0d required 0", mism, first); end
        @(negedge clk);
        checks++;
        if (c_ws !== 32'd4 || c_busy !== 1'b0) begin
            failures++; $display("FAIL stop2_end ws=%0d busy=%b required ws=4 busy=0", c_ws, c_busy);
        end
    endtask

    task automatic test_fifo_fill;
        logic act[$];
        int acc_cyc[6];
        int idx, mism, first, max_cnt;
        logic acc, saw_not_ready;
        idx = 0; max_cnt = 0; saw_not_ready = 1'b0;
        @(posedge clk); #1;
        a_data = 32'd1; a_valid = 1'b1;
        for (int cyc = 0; cyc < 2 + 6 * 161; cyc++) begin
            @(negedge clk);
            act.push_back(a_tx);
            if (int'(a_count) > max_cnt) max_cnt = int'(a_count);
            if (a_ready === 1'b0) saw_not_ready = 1'b1;
            acc = a_valid && a_ready;
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 6) a_data = 32'(idx + 1); else a_valid = 1'b0;
            end
        end
        checks++;
        if (max_cnt != 4 || !saw_not_ready) begin
            failures++; $display("FAIL fill_full max_count=%0d ready_low=%b required 4 and 1", max_cnt, saw_not_ready);
        end
        checks++;
        if (idx != 6 || (acc_cyc[5] - acc_cyc[0]) != 163) begin
            failures++; $display("FAIL fill_word6_accept accepted=%0d delay=%0d required 6 and 163", idx, acc_cyc[5] - acc_cyc[0]);
        end
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        for (int k = 1; k <= 6; k++) begin model_word(4, 1, 1'b1, 64'(k)); exp_q.push_back(1'b1); end
        mism = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) if (act[i] !== exp_q[i]) begin mism++; if (first < 0) first = i; end
        checks++;
        if (mism != 0) begin failures++; $display("FAIL fill_wave mismatches=%0d first_cycle=%0d required 0", mism, first); end
        exp_ws_a += 6;
        @(negedge clk);
        checks++;
        if (a_ws !== 32'(exp_ws_a) || a_busy !== 1'b0) begin
            failures++; $display("FAIL fill_words_sent got=%0d busy=%b required=%0d busy=0", a_ws, a_busy, exp_ws_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] wq[$];
        logic act_a[$];
        logic act_b[$];
        int idx, mism, first;
        logic acc;
        wq.push_back(32'hFFFF_FFFF);
        wq.push_back(32'h0000_0000);
        for (int i = 0; i < 3; i++) wq.push_back($urandom);
        idx = 0;
        @(posedge clk); #1;
        a_data = wq[0]; a_valid = 1'b1;
        for (int cyc = 0; cyc < 2 + 5 * 161; cyc++) begin
            @(negedge clk);
            act_a.push_back(a_tx);
            act_b.push_back(b_tx);
            acc = a_valid && a_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < wq.size()) a_data = wq[idx]; else a_valid = 1'b0;
            end
        end
        checks++;
        if (act_a[161] !== 1'b1 || act_a[162] !== 1'b1 || act_a[163] !== 1'b0) begin
            failures++; $display("FAIL b2b_gap stop/idle/start got=%b%b%b required=110", act_a[161], act_a[162], act_a[163]);
        end
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        foreach (wq[k]) begin model_word(4, 1, 1'b1, 64'(wq[k])); exp_q.push_back(1'b1); end
        mism = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) if (act_a[i] !== exp_q[i]) begin mism++; if (first < 0) first = i; end
        checks++;
        if (mism != 0) begin failures++; $display("FAIL b2b_msb_wave mismatches=%0d first_cycle=%0d required 0", mism, first); end
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        foreach (wq[k]) begin model_word(4, 1, 1'b0, 64'(wq[k])); exp_q.push_back(1'b1); end
        mism = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) if (act_b[i] !== exp_q[i]) begin mism++; if (first < 0) first = i; end
        checks++;
        if (mism != 0) begin failures++; $display("FAIL b2b_lsb_wave mismatches=%0d first_cycle=%0d required 0", mism, first); end
        exp_ws_a += 5;
        @(negedge clk);
        checks++;
        if (a_ws !== 32'(exp_ws_a) || b_ws !== 32'(exp_ws_a)) begin
            failures++; $display("FAIL b2b_words_sent got a=%0d b=%0d required=%0d", a_ws, b_ws, exp_ws_a);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic act[$];
        logic [31:0] w;
        int mism, first, highs;
        @(posedge clk); #1; a_data = $urandom; a_valid = 1'b1;
        @(posedge clk); #1; a_data = $urandom;
        @(posedge clk); #1; a_data = $urandom;
        @(posedge clk); #1; a_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (a_count !== 3'd2 || a_busy !== 1'b1) begin
            failures++; $display("FAIL midrst_before count=%0d busy=%b required 2 and 1", a_count, a_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_tx, a_ready, a_busy, a_count} !== 6'b110_000 || a_ws !== 32'd0) begin
            failures++; $display("FAIL midrst_immediate tx/ready/busy/count got=%b ws=%0d required=110000 ws=0",
                                 {a_tx, a_ready, a_busy, a_count}, a_ws);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_tx === 1'b1 && a_count === 3'd0) highs++;
        end
        checks++;
        if (highs != 200 || a_ws !== 32'd0) begin
            failures++; $display("FAIL midrst_quiet idle_cycles=%0d ws=%0d required 200 and 0", highs, a_ws);
        end
        w = $urandom;
        @(posedge clk); #1;
        a_data = w; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        for (int i = 0; i < 161; i++) begin
            @(negedge clk);
            act.push_back(a_tx);
        end
        exp_q.delete();
        exp_q.push_back(1'b1);
        model_word(4, 1, 1'b1, 64'(w));
        mism = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) if (act[i] !== exp_q[i]) begin mism++; if (first < 0) first = i; end
        checks++;
        if (mism != 0) begin failures++; $display("FAIL midrst_resume_wave mismatches=%0d first_cycle=%0d required 0", mism, first); end
        @(negedge clk);
        checks++;
        if (a_ws !== 32'd1 || a_busy !== 1'b0 || a_tx !== 1'b1) begin
            failures++; $display("FAIL midrst_resume_end ws=%0d busy=%b tx=%b required ws=1 busy=0 tx=1", a_ws, a_busy, a_tx);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_float_word();
        test_stop_bits();
        test_fifo_fill();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
